// File: rtl/cpu_pkg.sv
// Shared types and default widths for the branch/status path of the controller.
package cpu_pkg;

    localparam int unsigned PC_W_DEF  = 9;
    localparam int unsigned OFF_W_DEF = 8;

    typedef enum logic [2:0] {
        COND_B   = 3'd0,
        COND_BEQ = 3'd1,
        COND_BNE = 3'd2,
        COND_BLT = 3'd3,
        COND_BLE = 3'd4
    } cond_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAITF = 2'd1,
        EVAL  = 2'd2,
        RESP  = 2'd3
    } sbu_state_e;

    // Condition flags in {Z,V,N} order, matching the status register layout.
    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition resolver: condition code plus {Z,V,N} -> taken.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  flags_t     flags,
    output logic       taken_c
);

    always_comb begin
        taken_c = 1'b0;
        case (cond)
            COND_B:   taken_c = 1'b1;
            COND_BEQ: taken_c = flags.z;
            COND_BNE: taken_c = !flags.z;
            COND_BLT: taken_c = flags.n ^ flags.v;
            COND_BLE: taken_c = (flags.n ^ flags.v) | flags.z;
            default:  taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_branch_unit.sv
// Status register plus branch resolution with valid/ready on request and response.
// Define STATUS_FWD_EN to forward same-cycle flags and skip the WAITF bubble.
module status_branch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned OFF_W = OFF_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_we,
    input  logic             Z_in,
    input  logic             V_in,
    input  logic             N_in,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [OFF_W-1:0] br_off,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [PC_W-1:0]  res_target,
    output logic [2:0]       status
);

    sbu_state_e       state;
    sbu_state_e       state_next;
    logic             accept;
    logic             eval_en;

    logic [2:0]       req_cond;
    logic [PC_W-1:0]  req_pc;
    logic [OFF_W-1:0] req_off;

    flags_t           flags_in;
    flags_t           eval_flags;
    logic             eval_taken_c;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_ext;

    assign flags_in = '{z: Z_in, v: V_in, n: N_in};

    // Next-state decode; a request is only taken in IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        eval_en    = 1'b0;
        case (state)
            IDLE: begin
                if (br_valid) begin
                    accept = 1'b1;
`ifdef STATUS_FWD_EN
                    state_next = EVAL;
`else
                    state_next = flag_we ? WAITF : EVAL;
`endif
                end
            end
            WAITF: state_next = EVAL;
            EVAL: begin
                eval_en    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            br_ready  <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            state     <= state_next;
            br_ready  <= (state_next == IDLE);
            res_valid <= (state_next == RESP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status <= 3'b000;
        end else if (flag_we) begin
            status <= flags_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_cond <= 3'b000;
            req_pc   <= '0;
            req_off  <= '0;
        end else if (accept) begin
            req_cond <= br_cond;
            req_pc   <= br_pc;
            req_off  <= br_off;
        end
    end

`ifdef STATUS_FWD_EN
    logic   fwd_sel;
    flags_t fwd_flags;

    // Snapshot of the flags written alongside the accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_sel   <= 1'b0;
            fwd_flags <= '0;
        end else if (accept) begin
            fwd_sel   <= flag_we;
            fwd_flags <= flags_in;
        end
    end

    assign eval_flags = fwd_sel ? fwd_flags : flags_t'(status);
`else
    assign eval_flags = flags_t'(status);
`endif

    branch_cond_eval u_cond (
        .cond    (req_cond),
        .flags   (eval_flags),
        .taken_c (eval_taken_c)
    );

    // Sign-extending cast; sums wrap silently modulo 2^PC_W.
    assign off_ext = PC_W'($signed(req_off));
    assign pc_inc  = req_pc + PC_W'(1);

    // Result registers read pre-edge status, so a flag write during EVAL is not seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_taken  <= 1'b0;
            res_target <= '0;
        end else if (eval_en) begin
            res_taken  <= eval_taken_c;
            res_target <= eval_taken_c ? (pc_inc + off_ext) : pc_inc;
        end
    end

endmodule

// File: doc/status_branch_unit.md
Name: status_branch_unit

Overview:
- Consumes the ALU's Z/V/N condition flags from a CMP (subtract) and holds them in a 3-bit status register.
- Resolves conditional branches against the latched flags and returns taken/not-taken plus the next PC to the fetch stage.
- Uses a valid/ready handshake on both the request and response sides.
- Sits between the ALU flag outputs and the PC-select logic of the controller.

Parameters:
- PC_W, 9, PC and target width in bits.
- OFF_W, 8, branch offset width; sign-extended to PC_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- flag_we  in  1  latch Z_in/V_in/N_in at this edge (CMP writeback).
- Z_in  in  1  ALU zero flag.
- V_in  in  1  ALU overflow flag.
- N_in  in  1  ALU negative flag.
- br_valid  in  1  branch request valid.
- br_ready  out  1  unit can accept a request.
- br_cond  in  3  condition code.
- br_pc  in  PC_W  PC of the branch instruction.
- br_off  in  OFF_W  signed word offset.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_taken  out  1  branch taken.
- res_target  out  PC_W  next PC.
- status  out  3  {Z,V,N} register contents.

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset values:
  - status=000, state=IDLE, br_ready=1, res_valid=0, res_taken=0, res_target=0.
  - Reset mid-operation discards any pending request or result next edge.
- Status register:
  - When flag_we=1, status <= {Z_in,V_in,N_in} at the edge.
  - Otherwise status holds.
  - flag_we is honoured in every state, including while a result is held.
- Condition codes (evaluated against status):
  - 000 B: always taken.
  - 001 BEQ: Z.
  - 010 BNE: !Z.
  - 011 BLT: N^V.
  - 100 BLE: (N^V)|Z.
  - 101..111: reserved, never taken.
- Target arithmetic:
  - Taken: res_target = br_pc + 1 + sext(br_off).
  - Not taken: res_target = br_pc + 1.
  - Both computed modulo 2^PC_W; wrap-around is silent, no flag.
- FSM states:
  - IDLE: br_ready=1.
    - On br_valid & !flag_we: capture cond/pc/off; go to EVAL.
    - On br_valid & flag_we (hazard): capture the request; go to WAITF.
  - WAITF: br_ready=0. One bubble so the new flags are visible. Go to EVAL.
  - EVAL: br_ready=0. Compute taken and target from the current status; register them; go to RESP.
  - RESP: res_valid=1; outputs stable. br_ready=0.
    - On res_ready: go to IDLE.
    - Otherwise hold.
- Latency:
  - Request accepted to res_valid: 2 cycles, or 3 on the hazard path.
  - Throughput: one branch per 3 cycles minimum.
- flag_we during EVAL changes status at the same edge that the result registers. The result must use pre-edge status.
- br_valid while br_ready=0 is ignored; the requester must hold it.

Optional Feature:
- Macro: STATUS_FWD_EN.
- Defined:
  - The hazard path forwards {Z_in,V_in,N_in} directly into evaluation.
  - WAITF is unused, and IDLE with br_valid&flag_we goes straight to EVAL using the forwarded flags.
  - Latency is always 2.
- Undefined: the WAITF bubble behaviour above applies.

Decomposition:
- Shared package (cpu_pkg):
  - cond_e enum (B, BEQ, BNE, BLT, BLE).
  - sbu_state_e enum (IDLE, WAITF, EVAL, RESP).
  - Default PC_W/OFF_W constants.
- One natural sub-module, branch_cond_eval: a combinational cond plus {Z,V,N} to taken function, reused by the controller.

Test Plan:
- Reset, then flag_we with Z_in=1 (status 100), then BEQ with pc=0x010, off=0x05 -> res_valid after 2 cycles, taken=1, target=0x016.
- status=001 (N=1, V=0), BLT with pc=0x1FE, off=0x03 -> taken=1, target=0x002 (wrap).
- status=000, BLE with off=0xFC (-4), pc=0x020 -> taken=0, target=0x021.
- Hazard: status=000, BNE issued in the same cycle as flag_we with Z_in=1 -> WAITF bubble, taken=0, latency 3. With STATUS_FWD_EN defined -> latency 2, taken=0.
- RESP with res_ready=0 for 4 cycles while flag_we toggles status -> outputs stable, br_ready=0, and status updates. res_ready=1 -> IDLE next edge.
- Reset asserted in EVAL -> next edge res_valid=0, br_ready=1, status=000. Then cond=110 -> taken=0, target=pc+1.
